ternary_unpacker: RTL and testbench

Streams a packed ternary polynomial out of the ternary-multiplier datapath, one coefficient per cycle. Accepts WORD_WIDTH-bit words over a valid/ready input and unpacks 2-bit ternary codes, LSB first. Emits each coefficient as a 2-bit two's-complement value over a valid/ready output. It is the reader-side counterpart of the packed-operand registers that hold polynomials for the multiplier.

---
 rtl/pq_ternary_pkg.sv | 24 ++
 rtl/ternary_coeff_decode.sv | 28 ++
 rtl/ternary_unpacker.sv | 168 ++++++++++++++++
 tb/tb_ternary_unpacker.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_ternary_pkg.sv
// Shared definitions for the ternary polynomial datapath.
// Contents:
//   TERN_*      2-bit ternary code constants (two's-complement coefficient form)
//   state_t     unpacker FSM state encoding
//   word_count  number of packed words per polynomial
package pq_ternary_pkg;

    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;
    localparam logic [1:0] TERN_INV  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Each word carries word_width/2 two-bit codes.
    function automatic int word_count(input int n_coeff, input int word_width);
        return n_coeff / (word_width / 2);
    endfunction

endpackage

// File: rtl/ternary_coeff_decode.sv
// Combinational decode of one packed 2-bit ternary code.
// Ports:
//   code_i     packed code from the word buffer
//   coeff_o    coefficient as 2-bit two's complement (0, +1, -1)
//   invalid_o  high for the reserved code; coeff_o is then forced to zero
module ternary_coeff_decode
    import pq_ternary_pkg::*;
(
    input  logic [1:0] code_i,
    output logic [1:0] coeff_o,
    output logic       invalid_o
);

    always_comb begin
        coeff_o   = TERN_ZERO;
        invalid_o = 1'b0;
        case (code_i)
            TERN_ZERO: coeff_o = TERN_ZERO;
            TERN_POS:  coeff_o = TERN_POS;
            TERN_NEG:  coeff_o = TERN_NEG;
            default: begin
                coeff_o   = TERN_ZERO;
                invalid_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ternary_unpacker.sv
// Streams a packed ternary polynomial out one coefficient per cycle.
// Words arrive on a valid/ready input; 2-bit codes are unpacked LSB first
// and emitted as two's-complement coefficients on a valid/ready output.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               begin one polynomial (only honoured in IDLE)
//   in_data/valid/ready packed word input
//   out_coeff/valid/ready/last  coefficient output, last on index N_COEFF-1
//   busy                high while unpacking
//   done                one-cycle pulse after the final coefficient is consumed
//   err                 sticky flag for reserved codes, cleared on start
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting words and emitting coefficients
// DONE  | one-cycle done pulse, then back to IDLE
module ternary_unpacker
    import pq_ternary_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int N_COEFF    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [1:0]            out_coeff,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int HALF    = WORD_WIDTH / 2;
    localparam int N_WORDS = word_count(N_COEFF, WORD_WIDTH);
    localparam int IDX_W   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CNT_W   = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
    localparam int WCNT_W  = $clog2(N_WORDS + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(N_COEFF - 1);
    localparam logic [WCNT_W-1:0] WORDS_TOTAL = WCNT_W'(N_WORDS);

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      coeff_cnt_q, coeff_cnt_d;
    logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic                  err_q, err_d;

    logic [1:0] code_sel;
    logic [1:0] dec_coeff;
    logic       dec_invalid;
    logic       run;
    logic       idx_at_last;
    logic       out_fire;
    logic       in_fire;

    // Select code idx; shifting by 2*idx keeps the select a plain barrel shift.
    assign code_sel = 2'(buf_q >> {idx_q, 1'b0});

    ternary_coeff_decode u_decode (
        .code_i    (code_sel),
        .coeff_o   (dec_coeff),
        .invalid_o (dec_invalid)
    );

    assign run         = (state_q == RUN);
    assign idx_at_last = (idx_q == IDX_LAST);

    assign out_valid = run && buf_valid_q;
    assign out_coeff = out_valid ? dec_coeff : TERN_ZERO;
    assign out_last  = out_valid && (coeff_cnt_q == CNT_LAST);
    assign out_fire  = out_valid && out_ready;

    // Refill is allowed in the same cycle the last code of the word is taken,
    // so a continuous stream sees no bubble between words.
    assign in_ready = run && (word_cnt_q < WORDS_TOTAL) &&
                      (!buf_valid_q || (out_fire && idx_at_last));
    assign in_fire  = in_valid && in_ready;

    assign busy = run;
    assign done = (state_q == DONE);
    assign err  = err_q;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        idx_d       = idx_q;
        coeff_cnt_d = coeff_cnt_q;
        word_cnt_d  = word_cnt_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    buf_valid_d = 1'b0;
                    idx_d       = '0;
                    coeff_cnt_d = '0;
                    word_cnt_d  = '0;
                    err_d       = 1'b0;
                end
            end

            RUN: begin
                if (out_fire) begin
                    coeff_cnt_d = coeff_cnt_q + CNT_W'(1);
                    if (dec_invalid) begin
                        err_d = 1'b1;
                    end
                    if (idx_at_last) begin
                        idx_d       = '0;
                        buf_valid_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (out_last) begin
                        state_d     = DONE;
                        buf_valid_d = 1'b0;
                    end
                end
                // A refill overrides the clear above.
                if (in_fire) begin
                    buf_d       = in_data;
                    buf_valid_d = 1'b1;
                    idx_d       = '0;
                    word_cnt_d  = word_cnt_q + WCNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            idx_q       <= '0;
            coeff_cnt_q <= '0;
            word_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            idx_q       <= idx_d;
            coeff_cnt_q <= coeff_cnt_d;
            word_cnt_q  <= word_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ternary_unpacker.sv
// Self-checking bench for ternary_unpacker: scoreboard of expected
// coefficients filled from every accepted word, drained on every out fire.
module tb_ternary_unpacker;

    localparam int WW = 32;
    localparam int NC = 256;
    localparam int NW = NC / (WW / 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    out_coeff;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    ternary_unpacker #(.WORD_WIDTH(WW), .N_COEFF(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_coeff (out_coeff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] coeff;
        logic       last;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_out   = 0;
    int          exp_idx = 0;
    int          cyc     = 0;
    int          first_cyc = 0;
    int          last_cyc  = 0;
    logic [1:0]  first4 [4];
    logic [WW-1:0] words [NW];
    bit          rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] model_decode(input logic [1:0] c);
        return (c == 2'b10) ? 2'b00 : c;
    endfunction

    // Output-ready driver: either held high or random per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit         stalled_prev = 1'b0;
        bit         last_fire_prev = 1'b0;
        logic [1:0] prev_coeff = '0;
        logic       prev_last = 1'b0;
        exp_t       e;
        exp_t       ne;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (stalled_prev) begin
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_coeff", 32'(out_coeff), 32'(prev_coeff));
                check_eq("stall_last",  32'(out_last),  32'(prev_last));
            end
            check_eq("done_pulse", 32'(done), 32'(last_fire_prev));
            last_fire_prev = 1'b0;
            if (out_valid && out_ready) begin
                check_eq("sb_empty_at_fire", 32'(sb.size() == 0), 32'd0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("coeff", 32'(out_coeff), 32'(e.coeff));
                    check_eq("last",  32'(out_last),  32'(e.last));
                end
                if (n_out < 4) first4[n_out] = out_coeff;
                if (n_out == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_out++;
                last_fire_prev = out_last;
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < WW / 2; k++) begin
                    ne.coeff = model_decode(in_data[2*k +: 2]);
                    ne.last  = (exp_idx == NC - 1);
                    sb.push_back(ne);
                    exp_idx++;
                end
            end
            stalled_prev = out_valid && !out_ready && !rst;
            prev_coeff   = out_coeff;
            prev_last    = out_last;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_out_last"},  32'(out_last),  32'd0);
        check_eq({tag, "_out_coeff"}, 32'(out_coeff), 32'd0);
        check_eq({tag, "_busy"},      32'(busy),      32'd0);
        check_eq({tag, "_done"},      32'(done),      32'd0);
        check_eq({tag, "_err"},       32'(err),       32'd0);
    endtask

    task automatic start_poly();
        @(posedge clk);
        #1;
        start   = 1'b1;
        n_out   = 0;
        exp_idx = 0;
        sb.delete();
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_start",     32'(busy),     32'd1);
        check_eq("in_ready_after_start", 32'(in_ready), 32'd1);
        check_eq("err_after_start",      32'(err),      32'd0);
    endtask

    task automatic feed_word(input logic [WW-1:0] w);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("feed_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit extra);
        bit ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (extra && in_valid) check_eq("extra_word_ready", 32'(in_ready), 32'd0);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("done_seen",        32'(ok),        32'd1);
        check_eq("coeff_count",      32'(n_out),     32'(NC));
        check_eq("sb_left",          32'(sb.size()), 32'd0);
        check_eq("busy_at_done",     32'(busy),      32'd0);
        check_eq("in_ready_at_done", 32'(in_ready),  32'd0);
    endtask

    task automatic run_poly(input bit start_mid, input bit extra);
        start_poly();
        for (int i = 0; i < NW; i++) begin
            if (start_mid && i == 6) start = 1'b1;
            feed_word(words[i]);
            start = 1'b0;
        end
        if (extra) begin
            in_valid = 1'b1;
            in_data  = $urandom;
        end
        wait_done(extra);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [WW-1:0] rand_valid_word();
        logic [WW-1:0] w = '0;
        int r;
        for (int k = 0; k < WW / 2; k++) begin
            r = $urandom_range(0, 2);
            w[2*k +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #1;
        rst = 1'b0;

        // All +1 stream, full throughput
        for (int i = 0; i < NW; i++) words[i] = 32'h5555_5555;
        run_poly(1'b0, 1'b0);
        check_eq("throughput_span", 32'(last_cyc - first_cyc + 1), 32'(NC));
        check_eq("err_all_pos", 32'(err), 32'd0);

        // LSB-first ordering
        words[0] = 32'h0000_00C4;
        for (int i = 1; i < NW; i++) words[i] = '0;
        run_poly(1'b0, 1'b0);
        check_eq("lsb_first0", 32'(first4[0]), 32'h0);
        check_eq("lsb_first1", 32'(first4[1]), 32'h1);
        check_eq("lsb_first2", 32'(first4[2]), 32'h0);
        check_eq("lsb_first3", 32'(first4[3]), 32'h3);

        // Random backpressure
        for (int i = 0; i < NW; i++) words[i] = rand_valid_word();
        rand_ready = 1'b1;
        run_poly(1'b0, 1'b0);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // Invalid code: sticky err
        words[0] = 32'h0000_0002;
        for (int i = 1; i < NW; i++) words[i] = '0;
        run_poly(1'b0, 1'b0);
        check_eq("err_first_coeff", 32'(first4[0]), 32'h0);
        check_eq("err_after_done", 32'(err), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("err_sticky_idle", 32'(err), 32'd1);

        // Reset mid-run at coefficient 100 (start_poly also checks err clears)
        start_poly();
        for (int i = 0; i < 7; i++) feed_word(rand_valid_word());
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (n_out >= 100) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("reach_coeff_100", 32'(ok), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < NW; i++) words[i] = rand_valid_word();
        run_poly(1'b0, 1'b0);

        // start during RUN and a 17th word are both ignored
        for (int i = 0; i < NW; i++) words[i] = rand_valid_word();
        run_poly(1'b1, 1'b1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
